pattern_scan_ctrl: RTL and testbench
====================================

Name: pattern_scan_ctrl

Overview:
- Sequencer and configuration controller for the serial sequence-detector datapath.
- Accepts parallel words from an upstream requester over a valid/ready handshake and serializes each word MSB-first, one bit per clock, into a programmable overlapping pattern matcher.
- Holds the match pattern and its length, counts matches and signals word completion.
- Generalises the fixed "101" Mealy detector into a runtime-configurable, stream-fed engine.

Parameters:
- DATA_W, 8, width of each input word (bits serialized per transaction).
- PAT_MAX, 8, maximum pattern length in bits.
- CNT_W, 16, width of the saturating match counter.
- Derived localparam LEN_W = $clog2(PAT_MAX)+1.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_we  in  1  configuration write strobe.
- cfg_pattern  in  PAT_MAX  pattern; only the low cfg_len bits are used, MSB of that slice is matched first.
- cfg_len  in  LEN_W  pattern length; legal range 1..PAT_MAX.
- s_valid  in  1  input word valid.
- s_data  in  DATA_W  input word.
- s_ready  out  1  controller can accept a word.
- busy  out  1  high while not IDLE.
- match_o  out  1  one-cycle pulse per detected match.
- match_cnt  out  CNT_W  saturating match count since last reset or config write.
- done  out  1  one-cycle pulse on word completion.
- cfg_err  out  1  one-cycle pulse on a rejected config write.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-word):
  - state=IDLE; pattern=101, len=3; history=0; seen=0.
  - match_cnt=0; match_o=0; done=0; cfg_err=0.
- States: IDLE, SHIFT, DONE.
- s_ready = (state==IDLE) & ~cfg_we; combinational. busy = (state!=IDLE).
- IDLE:
  - On s_valid&s_ready: latch s_data into the shift register, bit counter=DATA_W-1, go to SHIFT.
  - s_valid while not ready is held off; no loss, no side effect.
- SHIFT, each cycle:
  - Consume bit b = shift-register MSB; shift left.
  - history <= {history[PAT_MAX-2:0], b}.
  - seen <= min(seen+1, PAT_MAX).
  - match = (seen+1 >= len) && (low len bits of {history,b} == low len bits of pattern).
  - match_o <= match; match_cnt <= match_cnt + match, saturating at all-ones (no wrap).
  - After the DATA_W-th bit, go to DONE.
- DONE: done=1 for exactly this cycle; next state is IDLE.
- Latency and throughput:
  - Accept at edge k; bits consumed at edges k+1..k+DATA_W.
  - match_o for the bit consumed at edge j is high during the cycle after edge j. The last bit's match_o coincides with done.
  - IDLE again after edge k+DATA_W+1; one word per DATA_W+2 cycles.
- Matching is overlapping.
  - History and seen persist across words, so patterns may span word boundaries.
  - They are cleared only by reset or by an accepted config write.
- Config write:
  - Accepted only when state==IDLE and 1<=cfg_len<=PAT_MAX.
  - On accept: load pattern and len; clear history, seen and match_cnt.
- Rejected config writes (raise cfg_err for one cycle, change no state):
  - cfg_we with an illegal length.
  - cfg_we in SHIFT or DONE.
- cfg_we and s_valid in the same IDLE cycle: the config write wins, s_ready=0, and the word is taken on a later cycle.
- No X on outputs after reset. Unused pattern bits above len are don't-care.

Test Plan:
- Reset, then word 8'b1010_1000 with default 101 -> match_o at bits 3 and 5 (two pulses); done high one cycle at edge k+8; match_cnt=2; s_ready low for 9 cycles.
- Cross-word: word 8'b0000_0010, then 8'b1000_0000 -> no match in word 1; match_o on the first bit of word 2; match_cnt=1.
- cfg_pattern=4'b1111, cfg_len=4, then word 8'hFF -> match_cnt cleared to 0 by config; 5 matches (bits 4..8); match_cnt=5.
- Config errors:
  - cfg_len=0 -> cfg_err pulse, pattern stays 101.
  - cfg_we during SHIFT -> cfg_err pulse, in-flight word unaffected.
  - cfg_we together with s_valid in IDLE -> s_ready=0, config applied, word accepted next cycle.
- Reset asserted after 3 bits of a word -> outputs drop without waiting for a clock; pattern=101/3; a new word 8'b1010_0000 gives match_cnt=1 (history empty).
- CNT_W=2, pattern 1 with len=1, words 8'hFF twice -> match_cnt saturates at 3 and does not wrap; match_o still pulses per bit.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
`default_nettype none
// ============================================================================
// pattern_scan_ctrl : word-fed serializer driving a configurable overlapping
//                     pattern matcher with a saturating match counter.
// Revision 1.0
// ============================================================================
module pattern_scan_ctrl #(
  parameter int DATA_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 16,
  localparam int LEN_W  = $clog2(PAT_MAX) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               s_valid,
  input  logic [DATA_W-1:0]  s_data,
  output logic               s_ready,
  output logic               busy,
  output logic               match_o,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               done,
  output logic               cfg_err
);

  localparam int BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_shift;
  logic [BCNT_W-1:0]   r_bitcnt;
  logic [PAT_MAX-1:0]  r_hist;
  logic [PAT_MAX-1:0]  r_pat;
  logic [LEN_W-1:0]    r_seen;
  logic [LEN_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_match;
  logic                r_cfg_err;

  logic                w_accept;
  logic                w_cfg_legal;
  logic                w_cfg_ok;
  logic                w_bit;
  logic [PAT_MAX-1:0]  w_hist_nxt;
  logic [PAT_MAX-1:0]  w_mask;
  logic [LEN_W:0]      w_seen_p1;
  logic                w_match;

  assign w_accept    = s_valid & s_ready;
  assign w_cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_MAX));
  assign w_cfg_ok    = cfg_we && (r_state == S_IDLE) && w_cfg_legal;

  assign w_bit       = r_shift[DATA_W-1];
  assign w_hist_nxt  = (r_hist << 1) | PAT_MAX'(w_bit);
  assign w_seen_p1   = {1'b0, r_seen} + (LEN_W+1)'(1);

  // Only the low r_len bits of history and pattern take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  assign w_match = (r_state == S_SHIFT) &&
                   (w_seen_p1 >= {1'b0, r_len}) &&
                   (((w_hist_nxt ^ r_pat) & w_mask) == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy    = 1'b0;
        s_ready = ~cfg_we;
        if (w_accept) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (r_bitcnt == '0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_hist    <= '0;
      r_pat     <= PAT_MAX'(5);
      r_seen    <= '0;
      r_len     <= LEN_W'(3);
      r_cnt     <= '0;
      r_match   <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_match   <= w_match;
      r_cfg_err <= cfg_we & ~w_cfg_ok;
      if (w_cfg_ok) begin
        r_pat  <= cfg_pattern;
        r_len  <= cfg_len;
        r_hist <= '0;
        r_seen <= '0;
        r_cnt  <= '0;
      end else if (r_state == S_SHIFT) begin
        r_shift  <= r_shift << 1;
        r_bitcnt <= r_bitcnt - BCNT_W'(1);
        r_hist   <= w_hist_nxt;
        if (r_seen < LEN_W'(PAT_MAX)) r_seen <= r_seen + LEN_W'(1);
        // Counter sticks at all-ones rather than wrapping.
        if (w_match && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_accept) begin
        r_shift  <= s_data;
        r_bitcnt <= BCNT_W'(DATA_W - 1);
      end
    end
  end

  assign match_o   = r_match;
  assign match_cnt = r_cnt;
  assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_pattern_scan_ctrl.sv
`default_nettype none
// Directed bench for pattern_scan_ctrl: default-width instance plus a
// 2-bit-counter instance for saturation.
module tb_pattern_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_pattern = '0;
  logic [3:0]  cfg_len = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, busy, match_o, done, cfg_err;
  logic [15:0] match_cnt;

  logic        t_cfg_we = 1'b0;
  logic [7:0]  t_cfg_pattern = '0;
  logic [3:0]  t_cfg_len = '0;
  logic        t_valid = 1'b0;
  logic [7:0]  t_data = '0;
  logic        t_ready, t_busy, t_match, t_done, t_cfg_err;
  logic [1:0]  t_cnt;

  int n_checks = 0;
  int n_err    = 0;
  bit sel      = 1'b0;

  always #5 clk = ~clk;

  pattern_scan_ctrl #(.DATA_W(8), .PAT_MAX(8), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .busy(busy), .match_o(match_o), .match_cnt(match_cnt), .done(done),
    .cfg_err(cfg_err)
  );

  pattern_scan_ctrl #(.DATA_W(8), .PAT_MAX(8), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .cfg_we(t_cfg_we), .cfg_pattern(t_cfg_pattern),
    .cfg_len(t_cfg_len), .s_valid(t_valid), .s_data(t_data), .s_ready(t_ready),
    .busy(t_busy), .match_o(t_match), .match_cnt(t_cnt), .done(t_done),
    .cfg_err(t_cfg_err)
  );

  logic        m_ready, m_busy, m_match, m_done;
  logic [31:0] m_cnt;
  assign m_ready = sel ? t_ready : s_ready;
  assign m_busy  = sel ? t_busy  : busy;
  assign m_match = sel ? t_match : match_o;
  assign m_done  = sel ? t_done  : done;
  assign m_cnt   = sel ? 32'(t_cnt) : 32'(match_cnt);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_word(input logic [7:0] d);
    if (sel) begin t_valid = 1'b1; t_data = d; end
    else begin s_valid = 1'b1; s_data = d; end
    #1;
    chk("ready_before_accept", 32'(m_ready), 32'd1);
    tick();
    t_valid = 1'b0;
    s_valid = 1'b0;
    chk("busy_after_accept", 32'(m_busy), 32'd1);
  endtask

  // Walks the 8 bit-consumption edges, then the DONE edge. cfg_at>=0 fires a
  // legal config write on the main instance during that SHIFT cycle.
  task automatic run_bits(input string tag, input logic [7:0] exp_vec,
                          input int exp_cnt, input int cfg_at);
    logic [7:0] v;
    v = exp_vec;
    for (int i = 0; i < 8; i++) begin
      if (i == cfg_at) begin
        cfg_we = 1'b1; cfg_pattern = 8'h0F; cfg_len = 4'd4;
      end
      tick();
      if (i == cfg_at) begin
        cfg_we = 1'b0;
        chk({tag, "_cfg_err_shift"}, 32'(cfg_err), 32'd1);
      end
      chk($sformatf("%s_match_bit%0d", tag, i + 1), 32'(m_match), 32'(v[7-i]));
      chk($sformatf("%s_ready_bit%0d", tag, i + 1), 32'(m_ready), 32'd0);
      chk($sformatf("%s_done_bit%0d", tag, i + 1), 32'(m_done), (i == 7) ? 32'd1 : 32'd0);
    end
    tick();
    chk({tag, "_done_drop"}, 32'(m_done), 32'd0);
    chk({tag, "_idle_ready"}, 32'(m_ready), 32'd1);
    chk({tag, "_idle_busy"}, 32'(m_busy), 32'd0);
    chk({tag, "_cnt"}, m_cnt, 32'(exp_cnt));
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    tick();
  endtask

  initial begin
    #12;
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_match", 32'(match_o), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);
    reset = 1'b0;
    tick();

    // Default 101 pattern, matches at bits 3 and 5.
    accept_word(8'b1010_1000);
    run_bits("w101", 8'b0010_1000, 2, -1);

    // Pattern spanning a word boundary from a clean history.
    pulse_reset();
    accept_word(8'b0000_0010);
    run_bits("xw1", 8'b0000_0000, 0, -1);
    accept_word(8'b1000_0000);
    run_bits("xw2", 8'b1000_0000, 1, -1);

    // Config 1111/4 clears the count; FF matches on bits 4..8.
    cfg_we = 1'b1; cfg_pattern = 8'h0F; cfg_len = 4'd4;
    #1;
    chk("cfg_ready_low", 32'(s_ready), 32'd0);
    tick();
    cfg_we = 1'b0;
    chk("cfg_ok_err", 32'(cfg_err), 32'd0);
    chk("cfg_clr_cnt", 32'(match_cnt), 32'd0);
    accept_word(8'hFF);
    run_bits("p1111", 8'b0001_1111, 5, -1);

    // Illegal lengths are rejected and change nothing.
    pulse_reset();
    cfg_we = 1'b1; cfg_pattern = 8'hFF; cfg_len = 4'd0;
    tick();
    cfg_we = 1'b0;
    chk("len0_err", 32'(cfg_err), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    tick();
    chk("len0_err_drop", 32'(cfg_err), 32'd0);
    accept_word(8'b1010_0000);
    run_bits("len0_keep", 8'b0010_0000, 1, -1);
    cfg_we = 1'b1; cfg_pattern = 8'hFF; cfg_len = 4'd9;
    tick();
    cfg_we = 1'b0;
    chk("len9_err", 32'(cfg_err), 32'd1);
    chk("len9_cnt_kept", 32'(match_cnt), 32'd1);

    // Config during SHIFT is rejected; word still matched with 101.
    accept_word(8'b0101_0000);
    run_bits("cfg_shift", 8'b0001_0000, 2, 2);

    // Config and word in the same IDLE cycle: config wins, word next cycle.
    cfg_we = 1'b1; cfg_pattern = 8'h03; cfg_len = 4'd2;
    s_valid = 1'b1; s_data = 8'b0110_1110;
    #1;
    chk("both_ready_low", 32'(s_ready), 32'd0);
    tick();
    cfg_we = 1'b0;
    chk("both_not_taken", 32'(busy), 32'd0);
    chk("both_cfg_err", 32'(cfg_err), 32'd0);
    chk("both_cnt_clr", 32'(match_cnt), 32'd0);
    accept_word(8'b0110_1110);
    run_bits("p11", 8'b0010_0110, 3, -1);

    // Asynchronous reset in the middle of a word.
    accept_word(8'hFF);
    tick(); tick(); tick();
    chk("mid_match_pre", 32'(match_o), 32'd1);
    chk("mid_cnt_pre", 32'(match_cnt), 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_match", 32'(match_o), 32'd0);
    chk("mid_cnt", 32'(match_cnt), 32'd0);
    chk("mid_ready", 32'(s_ready), 32'd1);
    #2 reset = 1'b0;
    tick();
    accept_word(8'b1010_0000);
    run_bits("post_rst", 8'b0010_0000, 1, -1);

    // Saturation on the 2-bit counter instance.
    sel = 1'b1;
    t_cfg_we = 1'b1; t_cfg_pattern = 8'h01; t_cfg_len = 4'd1;
    tick();
    t_cfg_we = 1'b0;
    chk("sat_cfg_err", 32'(t_cfg_err), 32'd0);
    accept_word(8'hFF);
    run_bits("sat1", 8'hFF, 3, -1);
    accept_word(8'hFF);
    run_bits("sat2", 8'hFF, 3, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
